fetch_controller: RTL and testbench
===================================

# fetch_controller

Instruction-fetch sequencer for the ARM pipeline, placed between the instruction memory and the IF/ID boundary of `ARM_TOP`. It owns the program counter and issues one request at a time to a variable-latency instruction memory using a req/ack handshake. It presents each fetched instruction with its PC+4 to the decode stage, and applies freeze (hazard stall) and branch flush. A skid buffer ensures no instruction is lost or duplicated across stalls.

## Interface
- `ADDR_W`, 32, PC / memory address width
- `INSTR_W`, 32, instruction word width
- `PC_STEP`, 4, PC increment per instruction
- `RESET_PC`, 0, PC value after reset
- `clk`  in  1  single clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `freeze`  in  1  hazard stall from decode; hold IF/ID outputs
- `branch_taken`  in  1  flush request from execute
- `branch_addr`  in  ADDR_W  branch target, sampled when `branch_taken`=1
- `imem_req`  out  1  fetch request
- `imem_addr`  out  ADDR_W  fetch address, stable while `imem_req`=1
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle
- `imem_rdata`  in  INSTR_W  fetched word
- `pc_out`  out  ADDR_W  PC+PC_STEP of the presented instruction
- `instruction_memory_out`  out  INSTR_W  presented instruction
- `valid_out`  out  1  IF/ID register holds a live instruction

## Operation
- Registers: `pc`, state, skid buffer `hold_instr`, `pend` flag plus `pend_target`, and the IF/ID output registers.
- States: IDLE, FETCH, HOLD. Reset state is IDLE.
- IDLE: `imem_req`=0. The next edge moves to FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. The request is held with a constant address until `imem_ack`.
- FETCH, no ack: `valid_out`<=0, a bubble, unless `freeze`=1.
- FETCH, no ack, `branch_taken`=1: `pend`<=1 and `pend_target`<=`branch_addr`. A later branch overwrites the target (last wins). `valid_out`<=0.
- FETCH, ack, with `branch_taken`=1 or `pend`=1: the data is discarded. `pc`<=`branch_addr` if `branch_taken`, else `pend_target`. `pend`<=0, `valid_out`<=0, and the state stays FETCH.
- FETCH, ack, `freeze`=0: the output registers load {`pc`+PC_STEP, `imem_rdata`} and `valid_out`<=1. `pc`<=`pc`+PC_STEP.
- FETCH, ack, `freeze`=1: `hold_instr`<=`imem_rdata`, the outputs are held, and the state goes to HOLD. `pc` is unchanged.
- HOLD: `imem_req`=0. While `freeze`=1, all registers hold.
- HOLD, `freeze`=0: the outputs load {`pc`+PC_STEP, `hold_instr`} and `valid_out`<=1. `pc`<=`pc`+PC_STEP and the state goes to FETCH.
- HOLD, `branch_taken`=1: overrides `freeze`. The buffer is dropped, `pc`<=`branch_addr`, `valid_out`<=0, and the state goes to FETCH.
- Priority: `branch_taken` > `freeze` > normal advance. A flush always clears `valid_out` on the next edge, even under freeze.
- Arithmetic: `pc`+PC_STEP is modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0x00000000 with no flag.

## Timing
- Reset values, asserted asynchronously: `pc`=RESET_PC, state=IDLE, `imem_req`=0, `imem_addr`=RESET_PC, `pc_out`=0, `instruction_memory_out`=0, `valid_out`=0, `pend`=0.
- First request: `imem_req`=1 with `imem_addr`=RESET_PC in the cycle after the first rising edge following reset release.
- Latency: an instruction acked in cycle N is on the outputs in cycle N+1.
- Throughput: a zero-wait memory (ack in the same cycle as req) gives one instruction per cycle.
- `imem_req` and `imem_addr` are decoded combinationally from registered state and `pc` only. They have no combinational path from `imem_ack`, `freeze` or `branch_taken`.
- HOLD exit: the buffered instruction appears the cycle after `freeze` falls. The next request is issued in that same cycle.
- Reset mid-transaction: the outstanding request is abandoned. The memory must tolerate `imem_req` dropping without an ack.

## Test plan
- Reset, `imem_ack` tied to 1, memory word[a]=a|0xE000_0000: `imem_addr` steps 0,4,8,…. `valid_out` rises 1 cycle after the first ack with `pc_out`=4 and `instruction_memory_out`=0xE000_0000, then advances each cycle.
- Ack after 3 wait cycles: `imem_addr` is stable at 0x8 for all 4 cycles and `valid_out`=0 during the wait. The instruction appears the cycle after ack with `pc_out`=0xC.
- `freeze` asserted for 3 cycles coincident with the ack at 0x10: outputs hold the previous instruction and `imem_req`=0 in HOLD. After release, the 0x10 word appears once with `pc_out`=0x14, and the next fetch is 0x14, with no skip or duplicate.
- `branch_taken`=1, `branch_addr`=0x100, in the same cycle as the ack for 0x20: the word is discarded, `valid_out`=0 the next cycle, and the next `imem_addr`=0x100.
- Two branches (0x200 then 0x300) during a 4-cycle wait: the request address is unchanged until ack, the acked data is dropped, and the next `imem_addr`=0x300.
- `rst` pulsed mid-wait and again while in HOLD: all outputs take their reset values immediately, without waiting for a clock edge. Fetch restarts at RESET_PC one cycle after release.

Source files
------------

// File: rtl/fetch_controller.sv
// fetch_controller: IF-stage sequencer owning the PC, the req/ack imem port,
// the IF/ID output registers and a one-entry skid buffer for freeze.
module fetch_controller #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] instruction_memory_out,
    output logic               valid_out
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pend_target_q;
    logic [ADDR_W-1:0]  pc_out_q;
    logic [INSTR_W-1:0] hold_instr_q;
    logic [INSTR_W-1:0] instr_q;
    logic               pend_q;
    logic               valid_q;
    logic [ADDR_W-1:0]  pc_inc;

    assign pc_inc = pc_q + ADDR_W'(PC_STEP);

    // Request side depends only on registered state, never on ack/freeze/branch.
    assign imem_req               = (state_q == FETCH);
    assign imem_addr              = pc_q;
    assign pc_out                 = pc_out_q;
    assign instruction_memory_out = instr_q;
    assign valid_out              = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
            pend_q        <= 1'b0;
            hold_instr_q  <= '0;
            pc_out_q      <= '0;
            instr_q       <= '0;
            valid_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    if (branch_taken) begin
                        pc_q <= branch_addr;
                    end
                end
                FETCH: begin
                    if (!imem_ack) begin
                        // Outstanding request keeps its address; remember the redirect.
                        if (branch_taken) begin
                            pend_q        <= 1'b1;
                            pend_target_q <= branch_addr;
                            valid_q       <= 1'b0;
                        end else if (!freeze) begin
                            valid_q <= 1'b0;
                        end
                    end else if (branch_taken || pend_q) begin
                        pc_q    <= branch_taken ? branch_addr : pend_target_q;
                        pend_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end else if (freeze) begin
                        hold_instr_q <= imem_rdata;
                        state_q      <= HOLD;
                    end else begin
                        pc_out_q <= pc_inc;
                        instr_q  <= imem_rdata;
                        valid_q  <= 1'b1;
                        pc_q     <= pc_inc;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        pc_q    <= branch_addr;
                        valid_q <= 1'b0;
                        state_q <= FETCH;
                    end else if (!freeze) begin
                        pc_out_q <= pc_inc;
                        instr_q  <= hold_instr_q;
                        valid_q  <= 1'b1;
                        pc_q     <= pc_inc;
                        state_q  <= FETCH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: randomized fetch stream against a path-level model,
// with a scoreboard of expected IF/ID presentations and directed corner cases.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_memory_out;
    logic        valid_out;

    int checks = 0;
    int failures = 0;
    int consumed = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];

    int fixed_lat = 0;
    bit rand_lat = 1'b0;
    int lat = 0;
    int cnt = 0;

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk                    (clk),
        .rst                    (rst),
        .freeze                 (freeze),
        .branch_taken           (branch_taken),
        .branch_addr            (branch_addr),
        .imem_req               (imem_req),
        .imem_addr              (imem_addr),
        .imem_ack               (imem_ack),
        .imem_rdata             (imem_rdata),
        .pc_out                 (pc_out),
        .instruction_memory_out (instruction_memory_out),
        .valid_out              (valid_out)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a | 32'hE000_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // The decode stage will see the straight-line path from address a.
    function automatic void redirect(input logic [31:0] a);
        exp_t e;
        sb.delete();
        for (int i = 0; i < 300; i++) begin
            e.pc  = a + 32'(4 * (i + 1));
            e.ins = mem_word(a + 32'(4 * i));
            sb.push_back(e);
        end
    endfunction

    // Variable-latency memory: ack after lat wait cycles, garbage otherwise.
    initial begin
        imem_ack = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !imem_req) begin
                imem_ack = 1'b0;
                imem_rdata = $urandom;
                cnt = 0;
            end else begin
                if (cnt == 0) lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
                if (cnt == lat) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    cnt = 0;
                end else begin
                    imem_ack = 1'b0;
                    imem_rdata = $urandom;
                    cnt++;
                end
            end
        end
    end

    // Monitor: decode consumes when valid and neither stalled nor flushed.
    initial begin
        exp_t e;
        logic prev_req;
        logic prev_ack;
        logic [31:0] prev_addr;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (valid_out && !freeze && !branch_taken) begin
                    consumed++;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_empty actual pc_out=%h expected none", pc_out);
                    end else begin
                        e = sb.pop_front();
                        check("sb_pc_out", pc_out, e.pc);
                        check("sb_instr", instruction_memory_out, e.ins);
                    end
                end
                if (prev_req && !prev_ack && imem_req)
                    check("addr_stable", imem_addr, prev_addr);
                prev_req = imem_req;
                prev_ack = imem_ack;
                prev_addr = imem_addr;
            end
        end
    end

    task automatic wait_addr(input logic [31:0] a);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (imem_addr !== a && n < 50);
        check("wait_addr", imem_addr, a);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_addr"}, imem_addr, 32'd0);
        check({tag, "_pc_out"}, pc_out, 32'd0);
        check({tag, "_instr"}, instruction_memory_out, 32'd0);
        check({tag, "_valid"}, 32'(valid_out), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        freeze = 1'b0;
        branch_taken = 1'b0;
        branch_addr = '0;
        #1 rst = 1'b1;
        #1 check_reset_outs("rst0");
        redirect(32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Zero-wait stream, then a 3-wait-cycle fetch at 0x8.
        @(negedge clk);
        check("idle_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);
        @(negedge clk);
        check("first_valid", 32'(valid_out), 32'd1);
        check("first_pc_out", pc_out, 32'h4);
        check("first_instr", instruction_memory_out, 32'hE000_0000);
        check("second_addr", imem_addr, 32'h4);
        fixed_lat = 3;
        @(negedge clk);
        check("wait_addr0", imem_addr, 32'h8);
        fixed_lat = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wait_addr_n", imem_addr, 32'h8);
            check("wait_bubble", 32'(valid_out), 32'd0);
        end
        @(negedge clk);
        check("wait_pc_out", pc_out, 32'hC);
        check("wait_valid", 32'(valid_out), 32'd1);

        // Freeze for 3 cycles coincident with the ack at 0x10.
        @(posedge clk);
        #1 freeze = 1'b1;
        @(negedge clk);
        check("frz_addr", imem_addr, 32'h10);
        check("frz_pc_out0", pc_out, 32'h10);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("hold_req1", 32'(imem_req), 32'd0);
        check("hold_pc_out", pc_out, 32'h10);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("hold_req2", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1 freeze = 1'b0;
        @(negedge clk);
        check("hold_req3", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("unhold_pc_out", pc_out, 32'h14);
        check("unhold_instr", instruction_memory_out, 32'hE000_0010);
        check("unhold_req", 32'(imem_req), 32'd1);
        check("unhold_addr", imem_addr, 32'h14);

        // Branch coincident with the ack for 0x20.
        wait_addr(32'h1C);
        @(posedge clk);
        #1 branch_taken = 1'b1;
        branch_addr = 32'h100;
        redirect(32'h100);
        @(negedge clk);
        check("br_addr", imem_addr, 32'h20);
        @(posedge clk);
        #1 branch_taken = 1'b0;
        @(negedge clk);
        check("br_flush", 32'(valid_out), 32'd0);
        check("br_target", imem_addr, 32'h100);
        @(negedge clk);
        check("br_pc_out", pc_out, 32'h104);

        // Two branches during a long wait: last target wins.
        wait_addr(32'h108);
        fixed_lat = 4;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pend_addr1", imem_addr, 32'h10C);
        fixed_lat = 0;
        @(posedge clk);
        #1 branch_taken = 1'b1;
        branch_addr = 32'h200;
        redirect(32'h200);
        @(negedge clk);
        check("pend_addr2", imem_addr, 32'h10C);
        @(posedge clk);
        #1 branch_taken = 1'b0;
        @(negedge clk);
        check("pend_addr3", imem_addr, 32'h10C);
        @(posedge clk);
        #1 branch_taken = 1'b1;
        branch_addr = 32'h300;
        redirect(32'h300);
        @(negedge clk);
        check("pend_addr4", imem_addr, 32'h10C);
        @(posedge clk);
        #1 branch_taken = 1'b0;
        @(negedge clk);
        check("pend_ack", 32'(imem_ack), 32'd1);
        @(negedge clk);
        check("pend_target", imem_addr, 32'h300);
        check("pend_flush", 32'(valid_out), 32'd0);

        // PC wrap at the top of the address space.
        @(posedge clk);
        #1 branch_taken = 1'b1;
        branch_addr = 32'hFFFF_FFF8;
        redirect(32'hFFFF_FFF8);
        @(negedge clk);
        @(posedge clk);
        #1 branch_taken = 1'b0;
        @(negedge clk);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        check("wrap_pc1", pc_out, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_addr2", imem_addr, 32'h0);
        check("wrap_pc2", pc_out, 32'h0);

        // Asynchronous reset in the middle of a wait.
        fixed_lat = 3;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_wait_req", 32'(imem_req), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outs("rst_wait");
        redirect(32'h0);
        fixed_lat = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst1_idle", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("rst1_req", 32'(imem_req), 32'd1);
        check("rst1_addr", imem_addr, 32'h0);

        // Asynchronous reset while holding a frozen instruction.
        @(posedge clk);
        #1 freeze = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("hold2_req", 32'(imem_req), 32'd0);
        check("hold2_valid", 32'(valid_out), 32'd1);
        check("hold2_pc_out", pc_out, 32'h4);
        #2 rst = 1'b1;
        #1 check_reset_outs("rst_hold");
        freeze = 1'b0;
        redirect(32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst2_idle", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("rst2_req", 32'(imem_req), 32'd1);
        check("rst2_addr", imem_addr, 32'h0);

        // Randomized traffic: latency, freeze and branches.
        rand_lat = 1'b1;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            freeze = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 19) == 0);
            if (branch_taken) begin
                if ($urandom_range(0, 7) == 0)
                    branch_addr = 32'hFFFF_FFF0 | ($urandom & 32'hC);
                else
                    branch_addr = $urandom & 32'hFFFF_FFFC;
                redirect(branch_addr);
            end
        end
        @(posedge clk);
        #1 freeze = 1'b0;
        branch_taken = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("progress", 32'(consumed > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
